// File: rtl/pwm_multi_if.sv
// Configuration and output bundle for the pwm_multi timebase/compare block.
// The master side supplies enable and configuration; the slave side (the PWM
// engine) returns the busy flag, the period strobe and the PWM outputs.
interface pwm_multi_if #(
  parameter int R = 8,
  parameter int N = 4,
  parameter int P = 8
);
  logic           en;
  logic           cfg_valid;
  logic [P-1:0]   cfg_prescale;
  logic [R-1:0]   cfg_period;
  logic           cfg_center;
  logic [N*R-1:0] cfg_duty;
  logic [N-1:0]   cfg_polarity;
  logic           cfg_busy;
  logic           period_tick;
  logic [N-1:0]   pwm_out;

  modport master (
    output en, cfg_valid, cfg_prescale, cfg_period, cfg_center, cfg_duty, cfg_polarity,
    input  cfg_busy, period_tick, pwm_out
  );

  modport slave (
    input  en, cfg_valid, cfg_prescale, cfg_period, cfg_center, cfg_duty, cfg_polarity,
    output cfg_busy, period_tick, pwm_out
  );
endinterface

// File: rtl/pwm_multi.sv
// N-channel PWM generator on one shared timebase (prescaler + edge/center
// counter). Configuration is staged in pending registers and promoted to the
// active set only at a period boundary, so pulses are never truncated.
module pwm_multi #(
  parameter int R = 8,
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  pwm_multi_if.slave  bus
);

  logic [P-1:0]   prescale_act_q, prescale_act_d, prescale_pend_q, prescale_pend_d;
  logic [R-1:0]   period_act_q,   period_act_d,   period_pend_q,   period_pend_d;
  logic           center_act_q,   center_act_d,   center_pend_q,   center_pend_d;
  logic [N*R-1:0] duty_act_q,     duty_act_d,     duty_pend_q,     duty_pend_d;
  logic [N-1:0]   pol_act_q,      pol_act_d,      pol_pend_q,      pol_pend_d;
  logic           busy_q, busy_d;
  logic [P-1:0]   psc_q, psc_d;
  logic [R-1:0]   cnt_q, cnt_d;
  logic           down_q, down_d;
  logic           ptick_q, ptick_d;
  logic [N-1:0]   pwm_q, pwm_d;

  logic tick;
  logic center_eff;
  logic boundary;

  // Timebase decode: prescaler tick and period-boundary detection. Center
  // mode with period 0 or 1 degenerates to edge counting (same sequence).
  always_comb begin
    tick       = bus.en && (psc_q == prescale_act_q);
    center_eff = center_act_q && (period_act_q > R'(1));
    boundary   = 1'b0;
    if (tick) begin
      if (center_eff) boundary = down_q && (cnt_q == R'(1));
      else            boundary = (cnt_q == period_act_q);
    end
  end

  // Next-state for prescaler, counter/direction, shadow config and busy.
  always_comb begin
    psc_d           = psc_q;
    cnt_d           = cnt_q;
    down_d          = down_q;
    ptick_d         = boundary;
    busy_d          = busy_q;
    prescale_act_d  = prescale_act_q;
    period_act_d    = period_act_q;
    center_act_d    = center_act_q;
    duty_act_d      = duty_act_q;
    pol_act_d       = pol_act_q;
    prescale_pend_d = prescale_pend_q;
    period_pend_d   = period_pend_q;
    center_pend_d   = center_pend_q;
    duty_pend_d     = duty_pend_q;
    pol_pend_d      = pol_pend_q;

    if (!bus.en) begin
      psc_d  = '0;
      cnt_d  = '0;
      down_d = 1'b0;
    end else if (tick) begin
      psc_d = '0;
      if (boundary) begin
        cnt_d  = '0;
        down_d = 1'b0;
      end else if (!center_eff) begin
        cnt_d = cnt_q + R'(1);
      end else if (!down_q) begin
        if (cnt_q == period_act_q) begin
          cnt_d  = cnt_q - R'(1);
          down_d = 1'b1;
        end else begin
          cnt_d = cnt_q + R'(1);
        end
      end else begin
        cnt_d = cnt_q - R'(1);
      end
    end else begin
      psc_d = psc_q + P'(1);
    end

    // A new write always wins over a boundary transfer; while disabled it
    // bypasses the shadow stage and takes effect immediately.
    if (bus.cfg_valid) begin
      prescale_pend_d = bus.cfg_prescale;
      period_pend_d   = bus.cfg_period;
      center_pend_d   = bus.cfg_center;
      duty_pend_d     = bus.cfg_duty;
      pol_pend_d      = bus.cfg_polarity;
      if (!bus.en) begin
        prescale_act_d = bus.cfg_prescale;
        period_act_d   = bus.cfg_period;
        center_act_d   = bus.cfg_center;
        duty_act_d     = bus.cfg_duty;
        pol_act_d      = bus.cfg_polarity;
        busy_d         = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (boundary && busy_q) begin
      prescale_act_d = prescale_pend_q;
      period_act_d   = period_pend_q;
      center_act_d   = center_pend_q;
      duty_act_d     = duty_pend_q;
      pol_act_d      = pol_pend_q;
      busy_d         = 1'b0;
    end
  end

  // Per-channel compare against the current count, polarity applied.
  always_comb begin
    pwm_d = pol_act_q;
    for (int i = 0; i < N; i++) begin
      if (bus.en) pwm_d[i] = (cnt_q < duty_act_q[i*R +: R]) ^ pol_act_q[i];
    end
  end

  // State registers; asynchronous reset to the documented defaults.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_act_q  <= '0;
      period_act_q    <= '1;
      center_act_q    <= 1'b0;
      duty_act_q      <= '0;
      pol_act_q       <= '0;
      prescale_pend_q <= '0;
      period_pend_q   <= '1;
      center_pend_q   <= 1'b0;
      duty_pend_q     <= '0;
      pol_pend_q      <= '0;
      busy_q          <= 1'b0;
      psc_q           <= '0;
      cnt_q           <= '0;
      down_q          <= 1'b0;
      ptick_q         <= 1'b0;
      pwm_q           <= '0;
    end else begin
      prescale_act_q  <= prescale_act_d;
      period_act_q    <= period_act_d;
      center_act_q    <= center_act_d;
      duty_act_q      <= duty_act_d;
      pol_act_q       <= pol_act_d;
      prescale_pend_q <= prescale_pend_d;
      period_pend_q   <= period_pend_d;
      center_pend_q   <= center_pend_d;
      duty_pend_q     <= duty_pend_d;
      pol_pend_q      <= pol_pend_d;
      busy_q          <= busy_d;
      psc_q           <= psc_d;
      cnt_q           <= cnt_d;
      down_q          <= down_d;
      ptick_q         <= ptick_d;
      pwm_q           <= pwm_d;
    end
  end

  assign bus.cfg_busy    = busy_q;
  assign bus.period_tick = ptick_q;
  assign bus.pwm_out     = pwm_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: edge/center waveforms, prescaler, polarity,
// shadow-register timing, enable behaviour and asynchronous reset.
module tb_pwm_multi;
  localparam int R = 8;
  localparam int N = 4;
  localparam int P = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  pwm_multi_if #(.R(R), .N(N), .P(P)) bus ();

  pwm_multi #(.R(R), .N(N), .P(P)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int presc, input int per, input bit ctr,
                         input int d0, input int d1, input int d2, input int d3,
                         input logic [N-1:0] pol);
    bus.cfg_prescale = P'(presc);
    bus.cfg_period   = R'(per);
    bus.cfg_center   = ctr;
    bus.cfg_duty     = {R'(d3), R'(d2), R'(d1), R'(d0)};
    bus.cfg_polarity = pol;
  endtask

  // Load the staged cfg_* while disabled, then enable; returns just after the
  // edge that applied the config, with en=1 driven for the following cycle.
  task automatic start_cfg();
    bus.en = 1'b0;
    bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    check("busy_after_en0_load", 32'(bus.cfg_busy), 32'd0);
    bus.en = 1'b1;
  endtask

  task automatic measure(input string tag, input int ncyc,
                         input int e0, input int e1, input int e2, input int e3, input int etk);
    int h[4];
    int t;
    t = 0;
    for (int c = 0; c < 4; c++) h[c] = 0;
    for (int k = 0; k < ncyc; k++) begin
      step();
      for (int c = 0; c < 4; c++) h[c] += int'(bus.pwm_out[c]);
      t += int'(bus.period_tick);
    end
    check({tag, "_ch0_high"}, 32'(h[0]), 32'(e0));
    check({tag, "_ch1_high"}, 32'(h[1]), 32'(e1));
    check({tag, "_ch2_high"}, 32'(h[2]), 32'(e2));
    check({tag, "_ch3_high"}, 32'(h[3]), 32'(e3));
    check({tag, "_ticks"},    32'(t),    32'(etk));
  endtask

  initial begin
    logic [N-1:0] ev;
    int c;
    bus.en = 1'b0;
    bus.cfg_valid = 1'b0;
    set_cfg(0, 0, 1'b0, 0, 0, 0, 0, 4'b0000);
    #12;
    check("rst_pwm",   32'(bus.pwm_out),     32'd0);
    check("rst_busy",  32'(bus.cfg_busy),    32'd0);
    check("rst_ptick", 32'(bus.period_tick), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Edge mode, period 9: exact first period after enable, then steady counts
    set_cfg(0, 9, 1'b0, 3, 0, 10, 9, 4'b0000);
    start_cfg();
    for (int i = 0; i < 10; i++) begin
      step();
      ev = {1'(i < 9), 1'b1, 1'b0, 1'(i < 3)};
      check("edge_pat_pwm",   32'(bus.pwm_out),     32'(ev));
      check("edge_pat_ptick", 32'(bus.period_tick), 32'(i == 9));
    end
    measure("edge", 100, 30, 0, 100, 90, 10);

    // Prescale 1, period 3, active-low ch0
    set_cfg(1, 3, 1'b0, 2, 0, 0, 0, 4'b0001);
    start_cfg();
    for (int i = 0; i < 8; i++) begin
      step();
      check("psc_pat_ch0",   32'(bus.pwm_out[0]),  32'(i >= 4));
      check("psc_pat_ptick", 32'(bus.period_tick), 32'(i == 7));
    end
    measure("psc", 80, 40, 0, 0, 0, 10);
    bus.en = 1'b0;
    step();
    step();
    check("en0_hold_pwm",   32'(bus.pwm_out),     32'd1);
    check("en0_hold_ptick", 32'(bus.period_tick), 32'd0);

    // Center mode, period 4: sequence 0,1,2,3,4,3,2,1
    set_cfg(0, 4, 1'b1, 2, 4, 5, 0, 4'b0000);
    start_cfg();
    for (int i = 0; i < 8; i++) begin
      step();
      c = (i <= 4) ? i : 8 - i;
      ev = {1'b0, 1'b1, 1'(c < 4), 1'(c < 2)};
      check("ctr_pat_pwm",   32'(bus.pwm_out),     32'(ev));
      check("ctr_pat_ptick", 32'(bus.period_tick), 32'(i == 7));
    end
    measure("ctr", 80, 30, 70, 80, 0, 10);

    // Shadow update mid-period, then two writes while busy (last wins)
    set_cfg(0, 9, 1'b0, 3, 0, 0, 0, 4'b0000);
    start_cfg();
    for (int i = 0; i < 30; i++) begin
      step();
      ev[0] = (i < 10) ? 1'(i < 3) : (i < 20) ? 1'(i - 10 < 6) : 1'(i - 20 < 8);
      check("shadow_ch0",  32'(bus.pwm_out[0]), 32'(ev[0]));
      check("shadow_busy", 32'(bus.cfg_busy),
            32'((i >= 5 && i <= 8) || (i >= 13 && i <= 18)));
      bus.cfg_valid = 1'b0;
      if (i == 4)  begin set_cfg(0, 9, 1'b0, 6, 0, 0, 0, 4'b0000); bus.cfg_valid = 1'b1; end
      if (i == 12) begin set_cfg(0, 9, 1'b0, 7, 0, 0, 0, 4'b0000); bus.cfg_valid = 1'b1; end
      if (i == 14) begin set_cfg(0, 9, 1'b0, 8, 0, 0, 0, 4'b0000); bus.cfg_valid = 1'b1; end
    end
    bus.cfg_valid = 1'b0;

    // cfg_valid coincident with the boundary tick: deferred one full period
    set_cfg(0, 9, 1'b0, 3, 0, 0, 0, 4'b0000);
    start_cfg();
    for (int i = 0; i < 30; i++) begin
      step();
      ev[0] = (i < 20) ? 1'((i % 10) < 3) : 1'(i - 20 < 6);
      check("coinc_ch0",  32'(bus.pwm_out[0]), 32'(ev[0]));
      check("coinc_busy", 32'(bus.cfg_busy),   32'(i >= 9 && i <= 18));
      bus.cfg_valid = 1'b0;
      if (i == 8) begin set_cfg(0, 9, 1'b0, 6, 0, 0, 0, 4'b0000); bus.cfg_valid = 1'b1; end
    end
    bus.cfg_valid = 1'b0;

    // Write while disabled takes effect at once without busy
    set_cfg(0, 9, 1'b0, 5, 0, 0, 0, 4'b0000);
    start_cfg();
    measure("en0load", 100, 50, 0, 0, 0, 10);

    // Asynchronous reset in the middle of a pulse with a pending write
    set_cfg(0, 9, 1'b0, 3, 3, 3, 3, 4'b0000);
    start_cfg();
    step();
    set_cfg(0, 9, 1'b0, 6, 6, 6, 6, 4'b0000);
    bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    check("pre_rst_busy", 32'(bus.cfg_busy), 32'd1);
    check("pre_rst_pwm",  32'(bus.pwm_out),  32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_pwm",   32'(bus.pwm_out),     32'd0);
    check("midrst_busy",  32'(bus.cfg_busy),    32'd0);
    check("midrst_ptick", 32'(bus.period_tick), 32'd0);
    step();
    reset_n = 1'b1;
    measure("post_rst", 512, 0, 0, 0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
N-channel PWM generator sharing one programmable timebase: clock prescaler, programmable period, edge- or center-aligned counting. Per-channel duty and output polarity. All configuration passes through shadow registers and takes effect only at a period boundary, so no glitched or truncated pulses appear. Drives motor/LED/power stages; period_tick serves as a sync strobe for ADC triggering and software.

Parameters:
R, 8, counter/period/duty width in bits
N, 4, number of PWM channels
P, 8, prescaler width in bits

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
en  input  1  timebase enable
cfg_valid  input  1  single-cycle strobe; captures all cfg_* inputs into pending registers
cfg_prescale  input  P  tick every cfg_prescale+1 clk cycles
cfg_period  input  R  period terminal count
cfg_center  input  1  0 = edge-aligned, 1 = center-aligned
cfg_duty  input  N*R  channel i duty at bits [i*R +: R]
cfg_polarity  input  N  per channel: 1 = active-low output
cfg_busy  output  1  pending config not yet applied
period_tick  output  1  one-clk pulse at each period boundary
pwm_out  output  N  PWM outputs, registered

Behaviour:
- Reset (async): active and pending config regs clear to prescale=0, period=all-ones, center=0, duty=0, polarity=0. Counter=0, direction=up, prescaler=0. pwm_out=0, cfg_busy=0, period_tick=0.
- Prescaler: counts 0..prescale_active. A tick occurs in each cycle where it equals prescale_active, then it returns to 0. prescale=0 gives a tick every clk.
- Edge mode: the counter advances on each tick 0,1,...,period,0. Period length = (period+1) ticks. The boundary is the tick at which cnt==period.
- Center mode: counting goes up 0..period, then down period-1..1, then back to 0. Period length = 2*period ticks. The boundary is the tick at which cnt==1 while counting down. With period==0, center mode behaves as edge mode (cnt stuck at 0, boundary every tick).
- Compare, per channel: active = (cnt < duty_active[i]).
  - pwm_out[i] = active XOR polarity_active[i], registered, so it lags the counter by exactly 1 clk.
  - duty=0 gives a permanently inactive output.
  - duty > period (edge) or duty > period (center) gives a permanently active output.
  - In center mode, the active pulse is centered on cnt=0 with width 2*duty-1 ticks for 1<=duty<=period.
- Shadow load:
  - cfg_valid copies all cfg_* inputs into pending regs and sets cfg_busy=1 on the next clk.
  - At the boundary tick, if busy, pending is copied to active and cfg_busy clears in the same clk edge. The counter restarts at 0 with direction up, and the new values govern the next period.
- period_tick: asserted for 1 clk on the clk edge following the boundary tick, regardless of load.
- cfg_valid while busy: pending is overwritten (last write wins) and busy stays 1.
- cfg_valid in the same cycle as a boundary: cfg_valid has priority. Pending takes the new values, the transfer is deferred to the next boundary, and the old pending values are discarded.
- en=0:
  - Prescaler and counter are held at 0, direction up.
  - pwm_out drives the inactive level (polarity_active). No period_tick.
  - cfg_valid loads directly into active (and pending) on the next clk, and cfg_busy stays 0.
- en rising: counting starts from cnt=0 on the first tick. The first boundary follows a full period.
- Reset mid-period: all state returns immediately to reset values, with no partial pulse held.
- Arithmetic: counter is R bits and never exceeds period. Comparisons are unsigned. No wrap beyond period is possible.

Test Plan:
- Edge, prescale=0, period=9, duty0=3, duty1=0, duty2=10, duty3=9, pol=0, en=1:
  - ch0 high 3 of every 10 clk.
  - ch1 constant 0, ch2 constant 1.
  - ch3 high 9 of 10.
  - period_tick every 10 clk.
  - pwm_out lags the counter by 1 clk.
- Prescale=1, period=3, duty0=2, pol0=1 -> period 8 clk, ch0 low 4 clk / high 4 clk. With en=0, ch0 is held at 1.
- Center, prescale=0, period=4, duty0=2, duty1=4, duty2=5:
  - cnt sequence 0,1,2,3,4,3,2,1 repeating.
  - ch0 active 3 of 8, centered on cnt=0.
  - ch1 active 7 of 8.
  - ch2 constant active.
  - period_tick every 8 clk.
- Shadow update: running edge period=9, duty0=3; mid-period cfg_valid with duty0=6:
  - cfg_busy=1 until the boundary.
  - The current period keeps its 3-clk pulse.
  - The next period gives a 6-clk pulse and cfg_busy=0.
  - A second cfg_valid while busy with duty0=8: 8 wins.
- cfg_valid coincident with the boundary tick: the update applies one full period later. A cfg_valid with en=0 applies on the next clk with cfg_busy staying 0.
- Assert reset_n low mid-pulse -> pwm_out=0, cfg_busy=0 and config at defaults immediately. After release, edge period 256 clk with duty 0 gives constant 0.
